// File: rtl/piccolo_pkg.sv
// piccolo_pkg: shared Piccolo-80 key schedule constants, types and round constant function
package piccolo_pkg;
    localparam int PICCOLO80_NR = 25;
    localparam logic [31:0] CON80_XOR = 32'h0f1e2d3c;
    typedef enum logic [1:0] {SEL_K23, SEL_K01, SEL_K44} key_word_sel_e;
    typedef enum logic {IDLE, STREAM} state_e;
    // Round constant: c = i+1 replicated as c|00000|c|00|c|00000|c, then masked
    function automatic logic [31:0] con80(input logic [4:0] i);
        logic [4:0] c;
        c = i + 5'd1;
        return {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ CON80_XOR;
    endfunction
    // Key word selector indexed by i mod 5
    function automatic key_word_sel_e sel80(input logic [2:0] m);
        return (m == 3'd0 || m == 3'd2) ? SEL_K23 : (m == 3'd3) ? SEL_K44 : SEL_K01;
    endfunction
endpackage

// File: rtl/piccolo80_con_gen.sv
// piccolo80_con_gen: combinational Piccolo-80 round constant from the round index
module piccolo80_con_gen
    import piccolo_pkg::*;
(
    input  logic [4:0]  round,
    output logic [31:0] con
);
    assign con = con80(round);
endmodule

// File: rtl/piccolo80_keysched_seq.sv
// piccolo80_keysched_seq: streams the Piccolo-80 whitening key and 25 round-key pairs
module piccolo80_keysched_seq
    import piccolo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [79:0] key,
    output logic [63:0] wk,
    output logic        wk_valid,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [31:0] rk_pair,
    output logic [4:0]  rk_round,
    output logic        rk_last
);
    state_e state, state_nx;
    logic [79:0] k;
    logic [4:0] round;
    logic [2:0] m5;
    logic load, fire, done;
    logic [31:0] con, word;
    key_word_sel_e sel;
    logic [15:0] k0, k1, k2, k3, k4;

    assign {k0, k1, k2, k3, k4} = k;

    // Handshake decode and next-state: load in IDLE, leave STREAM on the last pair
    always_comb begin
        key_ready = (state == IDLE) && !rst;
        rk_valid = (state == STREAM);
        load = key_ready && key_valid;
        fire = rk_valid && rk_ready;
        done = fire && (round == 5'(PICCOLO80_NR - 1));
        state_nx = load ? STREAM : done ? IDLE : state;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // Key/whitening registers and round/mod-5 counters
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
            wk <= '0;
            wk_valid <= 1'b0;
            round <= '0;
            m5 <= '0;
        end else if (load) begin
            k <= key;
            wk <= {key[79:72], key[55:48], key[63:56], key[71:64],
                   key[15:8], key[23:16], key[31:24], key[7:0]};
            wk_valid <= 1'b1;
            round <= '0;
            m5 <= '0;
        end else if (fire) begin
            round <= done ? 5'd0 : round + 5'd1;
            m5 <= (m5 == 3'd4) ? 3'd0 : m5 + 3'd1;
        end
    end

    piccolo80_con_gen u_con (.round(round), .con(con));

    assign sel = sel80(m5);
    assign word = (sel == SEL_K23) ? {k2, k3} : (sel == SEL_K01) ? {k0, k1} : {k4, k4};
    assign rk_pair = rk_valid ? (con ^ word) : '0;
    assign rk_round = round;
    assign rk_last = rk_valid && (round == 5'(PICCOLO80_NR - 1));
endmodule

// File: tb/tb_piccolo80_keysched_seq.sv
// tb_piccolo80_keysched_seq: randomized checks of the Piccolo-80 key schedule stream
module tb_piccolo80_keysched_seq;
    logic        clk = 0;
    logic        rst = 1;
    logic        key_valid = 0;
    logic        key_ready;
    logic [79:0] key = '0;
    logic [63:0] wk;
    logic        wk_valid;
    logic        rk_valid;
    logic        rk_ready = 0;
    logic [31:0] rk_pair;
    logic [4:0]  rk_round;
    logic        rk_last;
    int total = 0;
    int bad = 0;
    logic [79:0] fixed_key = 80'h00112233445566778899;

    piccolo80_keysched_seq dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
        .wk(wk), .wk_valid(wk_valid), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_pair(rk_pair), .rk_round(rk_round), .rk_last(rk_last)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_wk(input logic [79:0] kk);
        logic [15:0] w0, w1, w3, w4;
        w0 = kk[79:64]; w1 = kk[63:48]; w3 = kk[31:16]; w4 = kk[15:0];
        return {w0[15:8], w1[7:0], w1[15:8], w0[7:0], w4[15:8], w3[7:0], w3[15:8], w4[7:0]};
    endfunction

    function automatic logic [31:0] ref_pair(input logic [79:0] kk, input int i);
        logic [31:0] c, cn, w;
        logic [15:0] w0, w1, w2, w3, w4;
        w0 = kk[79:64]; w1 = kk[63:48]; w2 = kk[47:32]; w3 = kk[31:16]; w4 = kk[15:0];
        c = 32'(i + 1);
        cn = ((c << 27) | (c << 17) | (c << 10) | c) ^ 32'h0f1e2d3c;
        case (i % 5)
            0, 2: w = {w2, w3};
            1, 4: w = {w0, w1};
            default: w = {w4, w4};
        endcase
        return cn ^ w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [79:0] kk, input logic hold);
        int n = 0;
        while (!key_ready && n < 200) begin step(); n++; end
        total++;
        if (!key_ready) begin bad++; $display("FAIL load_wait key_ready=%b required 1", key_ready); end
        key = kk;
        key_valid = 1;
        step();
        key_valid = hold;
        total++;
        if (wk !== ref_wk(kk) || wk_valid !== 1'b1) begin
            bad++; $display("FAIL load_wk wk=%h wk_valid=%b required %h 1", wk, wk_valid, ref_wk(kk));
        end
        total++;
        if (rk_valid !== 1'b1 || rk_round !== 5'd0) begin
            bad++; $display("FAIL load_first rk_valid=%b rk_round=%0d required 1 0", rk_valid, rk_round);
        end
    endtask

    task automatic stream(input logic [79:0] kk, input int pct, input int abort_at, output int hs, output int cyc);
        logic stalled = 0;
        logic [31:0] pp = '0;
        logic [4:0] pr = '0;
        logic pl = 0;
        hs = 0;
        cyc = 0;
        while (hs < 25 && cyc < 2000 && hs != abort_at) begin
            total++;
            if (rk_valid !== 1'b1 || key_ready !== 1'b0) begin
                bad++; $display("FAIL stream_ctl hs=%0d rk_valid=%b key_ready=%b required 1 0", hs, rk_valid, key_ready);
            end
            if (stalled) begin
                total++;
                if (rk_pair !== pp || rk_round !== pr || rk_last !== pl) begin
                    bad++; $display("FAIL stall_hold pair=%h round=%0d last=%b required %h %0d %b", rk_pair, rk_round, rk_last, pp, pr, pl);
                end
            end
            total++;
            if (rk_pair !== ref_pair(kk, hs) || rk_round !== 5'(hs) || rk_last !== (hs == 24)) begin
                bad++; $display("FAIL pair i=%0d got %h/%0d/%b required %h/%0d/%b", hs, rk_pair, rk_round, rk_last, ref_pair(kk, hs), hs, hs == 24);
            end
            total++;
            if (wk !== ref_wk(kk) || wk_valid !== 1'b1) begin
                bad++; $display("FAIL wk_hold wk=%h required %h", wk, ref_wk(kk));
            end
            rk_ready = ($urandom_range(99) < pct);
            if (rk_valid && rk_ready) hs++;
            stalled = rk_valid && !rk_ready;
            pp = rk_pair; pr = rk_round; pl = rk_last;
            step();
            cyc++;
        end
        rk_ready = 0;
        if (abort_at < 0) begin
            total++;
            if (hs != 25) begin bad++; $display("FAIL handshakes got %0d required 25", hs); end
            total++;
            if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
                bad++; $display("FAIL stream_end rk_valid=%b key_ready=%b required 0 1", rk_valid, key_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        rk_ready = 1;
        step();
        step();
        total++;
        if (key_ready !== 0 || wk !== '0 || wk_valid !== 0 || rk_valid !== 0 || rk_pair !== '0 || rk_round !== '0 || rk_last !== 0) begin
            bad++; $display("FAIL reset kr=%b wk=%h wkv=%b rkv=%b pair=%h round=%0d last=%b required all 0", key_ready, wk, wk_valid, rk_valid, rk_pair, rk_round, rk_last);
        end
        rst = 0;
        step();
        step();
        total++;
        if (key_ready !== 1 || rk_valid !== 0 || rk_pair !== '0) begin
            bad++; $display("FAIL post_reset key_ready=%b rk_valid=%b pair=%h required 1 0 0", key_ready, rk_valid, rk_pair);
        end
        rk_ready = 0;
    endtask

    task automatic test_fixed();
        int hs, cyc;
        load_key(fixed_key, 0);
        total++;
        if (wk !== 64'h0033221188776699) begin bad++; $display("FAIL fixed_wk wk=%h required 0033221188776699", wk); end
        total++;
        if (rk_pair !== 32'h43494f4a) begin bad++; $display("FAIL fixed_i0 pair=%h required 43494f4a", rk_pair); end
        stream(fixed_key, 100, -1, hs, cyc);
        total++;
        if (cyc != 25) begin bad++; $display("FAIL fixed_consecutive cycles=%0d required 25", cyc); end
        total++;
        if (ref_pair(fixed_key, 24) !== 32'hc73d6b16) begin bad++; $display("FAIL model_i24 got %h required c73d6b16", ref_pair(fixed_key, 24)); end
    endtask

    task automatic test_backpressure();
        int hs, cyc;
        load_key(fixed_key, 0);
        stream(fixed_key, 50, -1, hs, cyc);
        for (int r = 0; r < 3; r++) begin
            logic [79:0] kk;
            kk = {16'($urandom), $urandom, $urandom};
            step();
            load_key(kk, 0);
            stream(kk, 50, -1, hs, cyc);
        end
    endtask

    task automatic test_key_during_stream();
        int hs, cyc;
        logic [79:0] ka, kb;
        ka = {16'($urandom), $urandom, $urandom};
        kb = {16'($urandom), $urandom, $urandom};
        load_key(ka, 1);
        key = kb;
        stream(ka, 70, -1, hs, cyc);
        step();
        key_valid = 0;
        total++;
        if (wk !== ref_wk(kb) || rk_valid !== 1'b1 || rk_round !== 5'd0) begin
            bad++; $display("FAIL second_key wk=%h rk_valid=%b round=%0d required %h 1 0", wk, rk_valid, rk_round, ref_wk(kb));
        end
        stream(kb, 100, -1, hs, cyc);
    endtask

    task automatic test_reset_mid();
        int hs, cyc;
        logic [79:0] kk;
        kk = {16'($urandom), $urandom, $urandom};
        load_key(kk, 0);
        stream(kk, 100, 10, hs, cyc);
        total++;
        if (rk_round !== 5'd10) begin bad++; $display("FAIL mid_round round=%0d required 10", rk_round); end
        rst = 1;
        step();
        total++;
        if (rk_valid !== 0 || wk_valid !== 0 || wk !== '0 || rk_pair !== '0 || rk_round !== '0 || key_ready !== 0) begin
            bad++; $display("FAIL mid_reset rkv=%b wkv=%b wk=%h pair=%h round=%0d kr=%b required 0s", rk_valid, wk_valid, wk, rk_pair, rk_round, key_ready);
        end
        rst = 0;
        rk_ready = 1;
        step();
        step();
        total++;
        if (rk_valid !== 0 || rk_round !== '0) begin
            bad++; $display("FAIL idle_ready rk_valid=%b round=%0d required 0 0", rk_valid, rk_round);
        end
        rk_ready = 0;
        load_key(kk, 0);
        stream(kk, 100, -1, hs, cyc);
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_backpressure();
        test_key_during_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
